hex_line_tx: RTL
================

# hex_line_tx

Serializes a fixed-width ASCII hex string into a byte stream for a UART transmitter, optionally terminated with CR/LF. Sits directly downstream of `bits_to_hex`. Its parallel `ascii` output is captured on `start`, then sent most-significant character first through a valid/ready byte handshake. Used to print counters, addresses and debug words over the serial console.

## Interface
- `N_CHARS`, default 8: number of ASCII characters in `ascii`. Must be ≥ 1.
- `APPEND_CRLF`, default 1: when 1, send 8'h0D then 8'h0A after the last character; when 0, send no terminator.
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request to send one line. Sampled only in IDLE.
- `ascii` input 8*N_CHARS: character string. Byte i is `ascii[i*8+:8]`. Byte N_CHARS-1 is the most significant character.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `done` output 1: one-cycle pulse after the final byte of a line is accepted.
- `tx_data` output 8: byte offered to the transmitter.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: transmitter accepts the byte when `tx_valid && tx_ready`.

## Operation
- **Reset values:** FSM in IDLE; `busy`=0, `done`=0, `tx_valid`=0, `tx_data`=8'h00; character index = 0.
- **Capture:** in IDLE with `start`=1, latch `ascii` into an internal register and load the index with N_CHARS-1. Go to SEND_CHAR. Changes to `ascii` after capture have no effect on the line in progress.
- **SEND_CHAR:** `tx_data` = latched byte[index]; `tx_valid`=1.
  - On handshake with index>0, decrement the index.
  - On handshake with index==0, go to SEND_CR if `APPEND_CRLF`=1, else go to IDLE and pulse `done`.
- **SEND_CR:** `tx_data`=8'h0D, `tx_valid`=1. On handshake, go to SEND_LF.
- **SEND_LF:** `tx_data`=8'h0A, `tx_valid`=1. On handshake, go to IDLE and pulse `done`.
- **Handshake rules:**
  - Once `tx_valid` rises, `tx_data` holds stable and `tx_valid` stays high until the handshake.
  - `tx_valid` never depends combinationally on `tx_ready`.
  - All outputs are registered.
- **start while busy:** ignored. It is neither queued nor does it restart the line.
- **start during the done cycle:** the FSM is already in IDLE, so the request is accepted. This allows back-to-back lines.
- **Reset mid-line:** abort immediately and return to the reset values. No `done` pulse; the partial line is not resumed.
- **`tx_ready` held low:** stall indefinitely with no timeout.

## Timing
- `start` sampled in cycle t → first character valid at t+1.
- With `tx_ready` constantly 1:
  - One byte per cycle, N_CHARS+2 bytes (N_CHARS bytes if `APPEND_CRLF`=0).
  - Last byte accepted at t+N_CHARS+2.
  - At t+N_CHARS+3: `done`=1 and `busy`=0.
- Back-to-back lines run at one line per N_CHARS+3 cycles when `start` is held high.
- Each cycle with `tx_ready` low while `tx_valid` is high adds exactly one cycle of latency.

## Structure
- **Shared package `hex_line_pkg`:**
  - State enum `hex_line_state_t` with values IDLE, SEND_CHAR, SEND_CR, SEND_LF.
  - Constants `ASCII_CR` = 8'h0D and `ASCII_LF` = 8'h0A.
- **Index width:** `$clog2(N_CHARS)`, with a minimum of 1 bit so N_CHARS=1 is legal.
- **No sub-module.** The latch, index counter and FSM are inline; the intended size is roughly 150 lines.
- **Typical integration:** `bits_to_hex` output → `hex_line_tx` → `uart_tx`.

## Test plan
- **Basic line:** N_CHARS=8, `ascii`="DEADBEEF", `tx_ready`=1, single `start` pulse.
  - Required: bytes 'D','E','A','D','B','E','E','F',8'h0D,8'h0A on 10 consecutive cycles starting at t+1.
  - Required: `done` high for one cycle at t+11; `busy` high from t+1 to t+10.
- **Backpressure:** same stimulus, `tx_ready` toggling 1,0,1,0.
  - Required: identical byte order, `tx_data` stable through every stall, no duplicated or dropped byte, 20 cycles from the first byte to `done`.
- **Capture and ignored start:** change `ascii` to "00000000" and pulse `start` while the first line is busy.
  - Required: the original "DEADBEEF" line completes, and no second line is emitted.
- **Back-to-back:** hold `start`=1 for two lines; `ascii` = "12345678", then "9ABCDEF0" applied in the `done` cycle.
  - Required: the second line's first byte '9' appears in the cycle after `done`.
- **Reset mid-line:** assert `reset` after the 3rd byte is accepted.
  - Required: `tx_valid`=0, `busy`=0 and `done`=0 on the next cycle; a new `start` sends a complete line from its first character.
- **Parameter corners:** N_CHARS=1, `APPEND_CRLF`=0, `ascii`="7".
  - Required: exactly one byte 8'h37, then `done` in the following cycle.

Source files
------------

// File: rtl/hex_line_pkg.sv
// hex_line_pkg: shared state encoding and terminator characters for hex_line_tx
package hex_line_pkg;
  typedef enum logic [1:0] {IDLE, SEND_CHAR, SEND_CR, SEND_LF} hex_line_state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/hex_line_tx.sv
// hex_line_tx: serializes a latched ASCII string MSB-first over a valid/ready byte stream, optional CR/LF
module hex_line_tx
  import hex_line_pkg::*;
#(
  parameter int N_CHARS     = 8,
  parameter bit APPEND_CRLF = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*N_CHARS-1:0] ascii,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);
  localparam int IW = N_CHARS > 1 ? $clog2(N_CHARS) : 1;
  hex_line_state_t      state_q, state_d;
  logic [8*N_CHARS-1:0] line_q, line_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hs;
  assign hs       = tx_valid_q && tx_ready;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  // state, latched line, index and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  // next state: capture on start in IDLE, walk index down, then optional CR/LF
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        line_d  = ascii;
        idx_d   = IW'(N_CHARS - 1);
        state_d = SEND_CHAR;
      end
      SEND_CHAR: if (hs) begin
        if (idx_q != '0) idx_d = idx_q - IW'(1);
        else begin
          state_d = APPEND_CRLF ? SEND_CR : IDLE;
          done_d  = !APPEND_CRLF;
        end
      end
      SEND_CR: if (hs) state_d = SEND_LF;
      SEND_LF: if (hs) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs derived from the next state so they are valid straight out of flops
  always_comb begin
    busy_d     = state_d != IDLE;
    tx_valid_d = busy_d;
    tx_data_d  = state_d == SEND_CHAR ? line_d[8*idx_d +: 8] :
                 state_d == SEND_CR   ? ASCII_CR :
                 state_d == SEND_LF   ? ASCII_LF : 8'h00;
  end
endmodule
